// File: rtl/mem_writeback.sv
// Memory/writeback pipeline stage: retires non-memory results immediately and
// runs a single-outstanding bus transfer for loads and stores.
module mem_writeback #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_submit,
  output logic        o_ready,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  input  logic [7:0]  i_reg_ie,
  input  logic        i_mem_access,
  input  logic        i_mem_we,
  input  logic        i_mem_width,
  output logic [7:0]  o_reg_ie,
  output logic [15:0] o_reg_data,
  output logic        o_mem_exception,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_data,
  output logic [1:0]  o_mem_sel,
  input  logic        i_mem_ack,
  input  logic        i_mem_err,
  input  logic [15:0] i_mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    FAULT
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_count;
  logic [7:0]  wait_count_next;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [7:0]  reg_ie_q;
  logic        we_q;
  logic        width_q;
  logic        mem_accept;
  logic        misaligned;
  logic [15:0] load_data;

  assign o_ready    = (state == IDLE) & ~(i_submit & i_mem_access);
  assign mem_accept = (state == IDLE) & i_submit & i_mem_access;
  assign misaligned = ~i_mem_width & i_addr[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      wait_count <= 8'd0;
    end else begin
      state      <= state_next;
      wait_count <= wait_count_next;
    end
  end

  // Operand capture; the bus outputs are driven from these while a transfer is in flight.
  always_ff @(posedge i_clk) begin
    if (mem_accept) begin
      addr_q   <= i_addr;
      data_q   <= i_data;
      reg_ie_q <= i_reg_ie;
      we_q     <= i_mem_we;
      width_q  <= i_mem_width;
    end
  end

  assign o_mem_addr = addr_q;
  assign o_mem_we   = we_q;
  assign o_mem_sel  = width_q ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
  assign o_mem_data = width_q ? {data_q[7:0], data_q[7:0]} : data_q;
  assign load_data  = width_q ? {8'h00, (addr_q[0] ? i_mem_data[15:8] : i_mem_data[7:0])}
                              : i_mem_data;

  always_comb begin
    state_next      = state;
    wait_count_next = wait_count;
    o_reg_ie        = 8'h00;
    o_reg_data      = i_data;
    o_mem_exception = 1'b0;
    o_mem_req       = 1'b0;
    case (state)
      IDLE: begin
        wait_count_next = 8'd0;
        if (i_submit & ~i_mem_access) begin
          o_reg_ie = i_reg_ie;
        end
        if (mem_accept) begin
          state_next = misaligned ? FAULT : BUS;
        end
      end
      BUS: begin
        o_mem_req = 1'b1;
        // A bus error outranks an ack presented in the same cycle.
        if (i_mem_err) begin
          o_mem_exception = 1'b1;
          state_next      = IDLE;
        end else if (i_mem_ack) begin
          if (~we_q) begin
            o_reg_ie   = reg_ie_q;
            o_reg_data = load_data;
          end
          state_next = IDLE;
        end else if (wait_count == LAST_WAIT) begin
          o_mem_exception = 1'b1;
          state_next      = IDLE;
        end else begin
          wait_count_next = wait_count + 8'd1;
        end
      end
      FAULT: begin
        o_mem_exception = 1'b1;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Nothing observable leaves the stage while reset is held.
    if (i_rst) begin
      o_reg_ie        = 8'h00;
      o_mem_exception = 1'b0;
      o_mem_req       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Randomized self-checking bench for mem_writeback with a transaction-level
// reference model of each submitted instruction.
module tb_mem_writeback;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        submit;
  logic        ready;
  logic [15:0] addr;
  logic [15:0] data;
  logic [7:0]  regIe;
  logic        memAccess;
  logic        memWe;
  logic        memWidth;
  logic [7:0]  outRegIe;
  logic [15:0] outRegData;
  logic        memException;
  logic        memReq;
  logic        outMemWe;
  logic [15:0] memAddr;
  logic [15:0] memData;
  logic [1:0]  memSel;
  logic        memAck;
  logic        memErr;
  logic [15:0] memRdata;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mem_writeback #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_submit(submit),
    .o_ready(ready),
    .i_addr(addr),
    .i_data(data),
    .i_reg_ie(regIe),
    .i_mem_access(memAccess),
    .i_mem_we(memWe),
    .i_mem_width(memWidth),
    .o_reg_ie(outRegIe),
    .o_reg_data(outRegData),
    .o_mem_exception(memException),
    .o_mem_req(memReq),
    .o_mem_we(outMemWe),
    .o_mem_addr(memAddr),
    .o_mem_data(memData),
    .o_mem_sel(memSel),
    .i_mem_ack(memAck),
    .i_mem_err(memErr),
    .i_mem_data(memRdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Idle cycles carry random ack/err noise, which the stage must ignore outside BUS.
  task automatic idleInputs();
    submit    = 1'b0;
    memAccess = $urandom_range(0, 1);
    addr      = 16'($urandom);
    data      = 16'($urandom);
    regIe     = 8'($urandom);
    memAck    = $urandom_range(0, 1);
    memErr    = $urandom_range(0, 1);
    memRdata  = 16'($urandom);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    checkOutput({tag, "_req"}, 32'(memReq), 32'd0);
    checkOutput({tag, "_exc"}, 32'(memException), 32'd0);
    checkOutput({tag, "_regie"}, 32'(outRegIe), 32'd0);
  endtask

  // kind: 0 = ack, 1 = err, 2 = ack+err, 3 = no response; delay = BUS cycles before response.
  task automatic applyStimulus(input logic acc, input logic we, input logic width,
                               input logic [15:0] a, input logic [15:0] d, input logic [7:0] ie,
                               input int kind, input int delay, input logic [15:0] rdata);
    logic [15:0] expSel;
    logic [15:0] expData;
    logic [15:0] expLoad;
    logic        hasAck;
    logic        hasErr;
    logic        done;
    logic        expExc;
    logic        expWb;
    @(negedge clk);
    idleInputs();
    submit = 1'b1; memAccess = acc; memWe = we; memWidth = width;
    addr = a; data = d; regIe = ie;
    #1;
    checkOutput("accept_ready", 32'(ready), 32'(!acc));
    checkOutput("accept_req", 32'(memReq), 32'd0);
    checkOutput("accept_exc", 32'(memException), 32'd0);
    checkOutput("accept_regie", 32'(outRegIe), acc ? 32'd0 : 32'(ie));
    if (!acc) begin
      checkOutput("nonmem_data", 32'(outRegData), 32'(d));
      return;
    end
    if (!width && a[0]) begin
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("fault_exc", 32'(memException), 32'd1);
      checkOutput("fault_req", 32'(memReq), 32'd0);
      checkOutput("fault_regie", 32'(outRegIe), 32'd0);
      checkOutput("fault_ready", 32'(ready), 32'd0);
    end else begin
      expSel  = width ? 16'(1 << a[0]) : 16'd3;
      expData = width ? 16'(d[7:0]) * 16'd257 : d;
      expLoad = width ? 16'((rdata >> (8 * a[0])) & 16'hFF) : rdata;
      hasAck  = (kind == 0 || kind == 2);
      hasErr  = (kind == 1 || kind == 2);
      done    = 1'b0;
      for (int k = 0; k < TIMEOUT && !done; k++) begin
        @(negedge clk);
        idleInputs();
        memAck = (k == delay) && hasAck;
        memErr = (k == delay) && hasErr;
        memRdata = rdata;
        #1;
        checkOutput("bus_req", 32'(memReq), 32'd1);
        checkOutput("bus_ready", 32'(ready), 32'd0);
        checkOutput("bus_addr", 32'(memAddr), 32'(a));
        checkOutput("bus_we", 32'(outMemWe), 32'(we));
        checkOutput("bus_sel", 32'(memSel), 32'(expSel));
        checkOutput("bus_data", 32'(memData), 32'(expData));
        done   = (k == delay && kind != 3) || (k == TIMEOUT - 1);
        expExc = (k == delay && hasErr) || (k == TIMEOUT - 1 && !(k == delay && hasAck));
        expWb  = (k == delay) && hasAck && !hasErr && !we;
        checkOutput("bus_exc", 32'(memException), 32'(done && expExc));
        checkOutput("bus_regie", 32'(outRegIe), expWb ? 32'(ie) : 32'd0);
        if (expWb) checkOutput("load_data", 32'(outRegData), 32'(expLoad));
      end
    end
    @(negedge clk);
    idleInputs();
    #1;
    checkQuiet("bubble");
  endtask

  task automatic resetMidBus();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0, 3, 0, 16'h0);
    @(negedge clk);
    idleInputs();
    submit = 1'b1; memAccess = 1'b1; memWe = 1'b0; memWidth = 1'b0;
    addr = 16'h0010; regIe = 8'h20;
    @(negedge clk);
    idleInputs(); memAck = 1'b0; memErr = 1'b0;
    #1;
    checkOutput("rst_bus1_req", 32'(memReq), 32'd1);
    @(negedge clk);
    memAck = 1'b0; memErr = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; submit = 1'b0; memAck = 1'b1; memErr = 1'b0; memRdata = 16'hBEEF;
    #1;
    checkQuiet("rst_late_ack");
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    memWe = 1'b0; memWidth = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleInputs();
    #1;
    checkQuiet("reset");

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h7777, 16'h1234, 8'h04, 3, 0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0101, 16'h0000, 8'h10, 0, 2, 16'hABCD);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0200, 16'h5A5A, 8'h00, 0, 0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 8'h02, 0, 0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 8'h08, 3, 0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0042, 16'h0000, 8'h01, 2, 1, 16'h1122);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0044, 16'h0000, 8'h80, 0, TIMEOUT - 1, 16'hC0DE);
    resetMidBus();

    for (int n = 0; n < 200; n++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    16'($urandom), 16'($urandom), 8'(1 << $urandom_range(0, 7)),
                    $urandom_range(0, 3), $urandom_range(0, TIMEOUT + 1), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles o_mem_req may wait for ack/err before fault (range 1..255).
REQ-002 SHALL have i_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_submit  input  1  execute-stage instruction valid (one-cycle pulse).
REQ-005 SHALL have o_ready  output  1  stage can accept; drives execute i_next_ready.
REQ-006 SHALL have i_addr, i_data  input  16 each  ALU result / store data or writeback value.
REQ-007 SHALL have i_reg_ie  input  8  one-hot destination register enable.
REQ-008 SHALL have i_mem_access, i_mem_we, i_mem_width  input  1 each  memory op, write, 1=byte/0=word.
REQ-009 SHALL have o_reg_ie  output  8  and o_reg_data  output  16  register-file writeback.
REQ-010 SHALL have o_mem_exception  output  1  memory fault pulse to execute.
REQ-011 SHALL have o_mem_req, o_mem_we  output  1 each; o_mem_addr, o_mem_data  output  16 each; o_mem_sel  output  2  byte lanes.
REQ-012 SHALL have i_mem_ack, i_mem_err  input  1 each; i_mem_data  input  16  read data.

Function
REQ-013 SHALL implement states IDLE, BUS, FAULT; accept = i_submit & o_ready.
REQ-014 o_ready SHALL equal (state==IDLE) & ~(i_submit & i_mem_access), combinational.
REQ-015 Non-memory accept SHALL writeback in the same cycle: o_reg_ie=i_reg_ie, o_reg_data=i_data; state stays IDLE.
REQ-016 Outside writeback cycles o_reg_ie SHALL be 8'h00; o_reg_data is don't-care.
REQ-017 Memory accept in IDLE SHALL latch addr, data, reg_ie, we, width; go to BUS next cycle, or FAULT if word access with i_addr[0]=1.
REQ-018 In BUS, o_mem_req SHALL be 1 and o_mem_addr/we/data/sel stable until ack, err or timeout.
REQ-019 Word access: o_mem_sel=2'b11, o_mem_data=latched data.
REQ-020 Byte access: o_mem_sel=addr[0]?2'b10:2'b01; o_mem_data={data[7:0],data[7:0]}.
REQ-021 In BUS with i_mem_ack=1, i_mem_err=0: load SHALL writeback that cycle with latched reg_ie; store SHALL writeback nothing; next state IDLE.
REQ-022 Load data: word = i_mem_data; byte = zero-extended i_mem_data[15:8] if addr[0] else [7:0].
REQ-023 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without ack/err.
REQ-024 In BUS, i_mem_err=1 (wins over simultaneous ack) or counter==TIMEOUT-1 without ack SHALL assert o_mem_exception that cycle, suppress writeback, go IDLE.
REQ-025 FAULT SHALL last one cycle: o_mem_exception=1, o_mem_req=0, no writeback, then IDLE.
REQ-026 o_mem_exception SHALL be 0 in all other cycles; i_mem_ack/err outside BUS SHALL be ignored.
REQ-027 o_ready SHALL stay 0 in BUS and FAULT; first acceptable cycle is the one after completion (one-bubble minimum per memory op).

Reset
REQ-028 On i_rst at any state, next state SHALL be IDLE, counter 0, o_mem_req=0, o_mem_exception=0, o_reg_ie=0.
REQ-029 Reset mid-BUS SHALL abandon the transfer; a late i_mem_ack SHALL not cause writeback.
REQ-030 After reset deasserts, o_ready SHALL be 1 when i_submit is low.

Verification
REQ-031 Non-mem: submit addr=x, data=16'h1234, reg_ie=8'h04 -> same cycle o_reg_ie=8'h04, o_reg_data=16'h1234, o_ready=1, o_mem_req=0.
REQ-032 Byte load: addr=16'h0101, width=1, ack after 3 cycles with i_mem_data=16'hABCD -> o_mem_sel=2'b10 for 3 cycles, writeback 16'h00AB on ack cycle, o_ready=1 next cycle.
REQ-033 Word store: addr=16'h0200, data=16'h5A5A, reg_ie=0, ack immediately -> o_mem_we=1, sel=2'b11, o_mem_data=16'h5A5A, o_reg_ie=0.
REQ-034 Misaligned word load addr=16'h0003 -> no o_mem_req, o_mem_exception=1 exactly one cycle after accept, no writeback.
REQ-035 TIMEOUT=4, no ack -> o_mem_req high 4 cycles, o_mem_exception on 4th, IDLE next; ack+err same cycle -> exception, no writeback.
REQ-036 i_rst in 2nd BUS cycle then ack -> o_mem_req low after edge, no writeback, no exception.
